logic_op_arbiter: RTL and testbench
===================================

// Module: logic_op_arbiter
// PURPOSE
//  Shares one AND/OR/XOR/NOT logic unit between two requesters (e.g. switch-panel front end, test sequencer).
//  Each requester posts an opcode plus operands. The block arbitrates round-robin, latches the winner's operands,
//  computes one registered result and returns it tagged with the requester id.
//  Fixed 3-cycle service per operation; one operation in flight at a time.
// PARAMETERS
//  W     4      operand width of X/Y; AND/OR/XOR result width
//  ZW    2*W    width of Z operand and of result bus (NOT result)
//  CNTW  8      width of completed-operation counter
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  req0       in   1     requester 0 request; held high with stable op/operands until ack0
//  op0        in   2     requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOT
//  x0, y0     in   W     requester 0 operands for AND/OR/XOR
//  z0         in   ZW    requester 0 operand for NOT
//  req1/op1/x1/y1/z1 in  same as requester 0, for requester 1
//  ack0, ack1 out  1     one-cycle pulse: request accepted, operands captured
//  busy       out  1     high whenever state != IDLE
//  res        out  ZW    result; valid only while res_valid
//  res_valid  out  1     one-cycle pulse: res/res_id valid
//  res_id     out  1     id of requester owning res
//  op_count   out  CNTW  completed operations, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; ack0=ack1=busy=res_valid=0; res=0; res_id=0; op_count=0; last_id=1.
//  FSM IDLE -> EXEC -> DONE -> IDLE. All outputs registered.
//  - IDLE: sample req0/req1 on each edge. No req: stay IDLE.
//    Exactly one req: grant that requester.
//    Both req: grant ~last_id, so requester 0 wins the first contention after reset.
//    On grant: latch op/x/y/z of winner, gnt_id<=winner, last_id<=winner, go EXEC.
//  - EXEC: ack[gnt_id]=1 this cycle only. Compute into res:
//    00 {0,x&y}, 01 {0,x|y}, 10 {0,x^y}, 11 ~z; upper ZW-W bits zero for 00/01/10. Go DONE.
//  - DONE: res_valid=1, res_id=gnt_id this cycle only; op_count<=op_count+1. Go IDLE.
//  Latency: req sampled at edge k -> ack in cycle k+1 -> res_valid in cycle k+2 -> IDLE (re-arbitration) at edge k+3.
//  Requests arriving or changing in EXEC/DONE are ignored until IDLE. Operands are captured only at grant,
//  so later operand changes do not affect the in-flight result.
//  A requester holding req high after its ack is treated as a new request at the next IDLE sample.
//  Under continuous contention, grants strictly alternate 0,1,0,1...
//  res holds its last value between res_valid pulses; consumers must qualify with res_valid.
//  op_count wraps 2^CNTW-1 -> 0 with no flag.
//  Reset mid-operation: in-flight op discarded, no ack/res_valid emitted. Requesters still high are re-arbitrated
//  from IDLE after release, with last_id=1.
//  Output exclusivity: never ack0 & ack1; never ack and res_valid in the same cycle.
// TESTING
//  1 Reset: rst_n low mid-stream -> all outputs 0 same cycle (async); op_count=0.
//  2 Single op: req0, op=00, x=4'hC, y=4'hA -> ack0 at k+1; res=8'h08, res_valid, res_id=0 at k+2; op_count=1.
//  3 NOT split: req1, op=11, z=8'h3C -> res=8'hC3, res_id=1; op=10 x=4'hF y=4'h5 -> res=8'h0A.
//  4 Contention: req0=req1=1 held 4 grants -> order 0,1,0,1; ack pulses 3 cycles apart; never both acks.
//  5 Operand stability: change x0 during EXEC -> res reflects operands captured at grant.
//  6 Abort/wrap: rst_n low in EXEC -> no res_valid, re-grant req0 after release; 256 ops -> op_count 8'hFF->8'h00.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin shared AND/OR/XOR/NOT unit for two requesters
module logic_op_arbiter #(
    parameter int W    = 4,
    parameter int ZW   = 2 * W,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic [1:0]      op0,
    input  logic [W-1:0]    x0,
    input  logic [W-1:0]    y0,
    input  logic [ZW-1:0]   z0,
    input  logic            req1,
    input  logic [1:0]      op1,
    input  logic [W-1:0]    x1,
    input  logic [W-1:0]    y1,
    input  logic [ZW-1:0]   z1,
    output logic            ack0,
    output logic            ack1,
    output logic            busy,
    output logic [ZW-1:0]   res,
    output logic            res_valid,
    output logic            res_id,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            gnt_id_q, gnt_id_d;
    logic            last_id_q, last_id_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [ZW-1:0]   z_q, z_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            busy_q, busy_d;
    logic [ZW-1:0]   res_q, res_d;
    logic            res_valid_q, res_valid_d;
    logic            res_id_q, res_id_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            op_q        <= 2'b00;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            last_id_q   <= last_id_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        last_id_d   = last_id_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = 1'b0;
        res_d       = res_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        cnt_d       = cnt_q;
        win         = 1'b0;

        // Outputs are registered, so each is set on the edge entering the state that shows it.
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win       = (req0 && req1) ? ~last_id_q : req1;
                    state_d   = EXEC;
                    gnt_id_d  = win;
                    last_id_d = win;
                    op_d      = win ? op1 : op0;
                    x_d       = win ? x1 : x0;
                    y_d       = win ? y1 : y0;
                    z_d       = win ? z1 : z0;
                    ack0_d    = ~win;
                    ack1_d    = win;
                    busy_d    = 1'b1;
                end
            end
            EXEC: begin
                state_d     = DONE;
                busy_d      = 1'b1;
                res_valid_d = 1'b1;
                res_id_d    = gnt_id_q;
                case (op_q)
                    2'b00:   res_d = {{(ZW-W){1'b0}}, x_q & y_q};
                    2'b01:   res_d = {{(ZW-W){1'b0}}, x_q | y_q};
                    2'b10:   res_d = {{(ZW-W){1'b0}}, x_q ^ y_q};
                    default: res_d = ~z_q;
                endcase
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = busy_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - scoreboard bench for logic_op_arbiter
module tb_logic_op_arbiter;

    localparam int W    = 4;
    localparam int ZW   = 8;
    localparam int CNTW = 8;

    logic            clk;
    logic            rst_n;
    logic            req0, req1;
    logic [1:0]      op0, op1;
    logic [W-1:0]    x0, y0, x1, y1;
    logic [ZW-1:0]   z0, z1;
    logic            ack0, ack1, busy, res_valid, res_id;
    logic [ZW-1:0]   res;
    logic [CNTW-1:0] op_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [ZW:0] sb[$];

    logic_op_arbiter #(.W(W), .ZW(ZW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .x0(x0), .y0(y0), .z0(z0),
        .req1(req1), .op1(op1), .x1(x1), .y1(y1), .z1(z1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .res(res), .res_valid(res_valid), .res_id(res_id), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [ZW-1:0] model(input logic [1:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic [ZW-1:0] z);
        case (op)
            2'b00:   return {4'h0, x & y};
            2'b01:   return {4'h0, x | y};
            2'b10:   return {4'h0, x ^ y};
            default: return ~z;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [ZW:0] e;
        if (rst_n === 1'b1) begin
            check("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
            check("ack_rv_excl", {31'd0, (ack0 | ack1) & res_valid}, 32'd0);
        end
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("res", {24'd0, res}, {24'd0, e[ZW-1:0]});
                check("res_id", {31'd0, res_id}, {31'd0, e[ZW]});
            end
        end
    end

    task automatic do_op(input logic id, input logic [1:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [ZW-1:0] z);
        @(negedge clk);
        if (id) begin req1 = 1'b1; op1 = op; x1 = x; y1 = y; z1 = z; end
        else    begin req0 = 1'b1; op0 = op; x0 = x; y0 = y; z0 = z; end
        sb.push_back({id, model(op, x, y, z)});
        @(negedge clk);
        check("ack_lat", {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("rv_lat", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t;
        int last_cyc;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        x0 = 0; y0 = 0; x1 = 0; y1 = 0; z0 = 0; z1 = 0;
        last_cyc = 0;
        repeat (2) @(negedge clk);
        check("rst_outs", {28'd0, ack0, ack1, busy, res_valid}, 32'd0);
        check("rst_res", {23'd0, res_id, res}, 32'd0);
        check("rst_cnt", {24'd0, op_count}, 32'd0);
        rst_n = 1'b1;

        do_op(1'b0, 2'b00, 4'hC, 4'hA, 8'h00);
        check("single_res", {24'd0, res}, 32'h08);
        check("single_cnt", {24'd0, op_count}, 32'd1);

        do_op(1'b1, 2'b11, 4'h0, 4'h0, 8'h3C);
        check("not_res", {24'd0, res}, 32'hC3);
        do_op(1'b1, 2'b10, 4'hF, 4'h5, 8'hFF);
        check("xor_res", {24'd0, res}, 32'h0A);
        check("cnt3", {24'd0, op_count}, 32'd3);

        @(negedge clk);
        req0 = 1; op0 = 2'b00; x0 = 4'hC; y0 = 4'hA;
        req1 = 1; op1 = 2'b11; z1 = 8'h3C;
        for (int g = 0; g < 4; g++) begin
            sb.push_back({g[0], g[0] ? 8'hC3 : 8'h08});
        end
        for (int g = 0; g < 4; g++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!(ack0 | ack1) && t < 10);
            check("cont_timeout", {31'd0, t < 10}, 32'd1);
            check("cont_order", {30'd0, ack1, ack0}, g[0] ? 32'd2 : 32'd1);
            if (g > 0) check("cont_gap", cyc - last_cyc, 32'd3);
            last_cyc = cyc;
            if (g == 3) begin req0 = 0; req1 = 0; end
        end
        repeat (2) @(negedge clk);
        check("cont_cnt", {24'd0, op_count}, 32'd7);

        @(negedge clk);
        req0 = 1; op0 = 2'b01; x0 = 4'h3; y0 = 4'h4;
        sb.push_back({1'b0, 8'h07});
        @(negedge clk);
        check("stab_ack", {31'd0, ack0}, 32'd1);
        x0 = 4'hF; y0 = 4'h0; req0 = 0;
        repeat (2) @(negedge clk);
        check("stab_res", {24'd0, res}, 32'h07);

        @(negedge clk);
        req0 = 1; op0 = 2'b00; x0 = 4'hC; y0 = 4'hA;
        req1 = 1; op1 = 2'b11; z1 = 8'h3C;
        @(negedge clk);
        check("abort_grant1", {30'd0, ack1, ack0}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs", {28'd0, ack0, ack1, busy, res_valid}, 32'd0);
        check("abort_res", {23'd0, res_id, res}, 32'd0);
        check("abort_cnt", {24'd0, op_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back({1'b0, 8'h08});
        @(negedge clk);
        check("regrant0", {30'd0, ack1, ack0}, 32'd1);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
        check("regrant_cnt", {24'd0, op_count}, 32'd1);

        for (int i = 0; i < 254; i++) begin
            do_op(i[0], 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 8'($urandom));
        end
        check("cnt_ff", {24'd0, op_count}, 32'hFF);
        do_op(1'b0, 2'b01, 4'h1, 4'h2, 8'h00);
        check("cnt_wrap", {24'd0, op_count}, 32'h00);

        @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
